// File: rtl/pipelined_control_unit.sv
// LEGv8 pipelined control: decodes the ID opcode and carries its control word
// through ID/EX, EX/MEM and MEM/WB, with load-use bubble insertion and branch flush.
module pipelined_control_unit #(
    parameter int OPCODE_W = 11,
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [REG_W-1:0]    id_rn,
    input  logic [REG_W-1:0]    id_rm,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                flush,
    output logic                stall,
    output logic                id_illegal,
    output logic                ex_alusrc,
    output logic [1:0]          ex_aluop,
    output logic                mem_memread,
    output logic                mem_memwrite,
    output logic                mem_branch,
    output logic                mem_uncond,
    output logic                wb_regwrite,
    output logic                wb_memtoreg,
    output logic [REG_W-1:0]    ex_rd,
    output logic [REG_W-1:0]    mem_rd,
    output logic [REG_W-1:0]    wb_rd
);

    localparam logic [REG_W-1:0] ZERO_RD = REG_W'(ZERO_REG);

    typedef struct packed {
        logic             alusrc;
        logic [1:0]       aluop;
        logic             memread;
        logic             memwrite;
        logic             branch;
        logic             uncond;
        logic             regwrite;
        logic             memtoreg;
        logic [REG_W-1:0] rd;
    } ex_ctrl_t;

    typedef struct packed {
        logic             memread;
        logic             memwrite;
        logic             branch;
        logic             uncond;
        logic             regwrite;
        logic             memtoreg;
        logic [REG_W-1:0] rd;
    } mem_ctrl_t;

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic [REG_W-1:0] rd;
    } wb_ctrl_t;

    localparam ex_ctrl_t EX_BUBBLE = '{alusrc: 1'b0, aluop: 2'b00, memread: 1'b0,
                                       memwrite: 1'b0, branch: 1'b0, uncond: 1'b0,
                                       regwrite: 1'b0, memtoreg: 1'b0, rd: ZERO_RD};
    localparam mem_ctrl_t MEM_BUBBLE = '{memread: 1'b0, memwrite: 1'b0, branch: 1'b0,
                                         uncond: 1'b0, regwrite: 1'b0, memtoreg: 1'b0,
                                         rd: ZERO_RD};
    localparam wb_ctrl_t WB_BUBBLE = '{regwrite: 1'b0, memtoreg: 1'b0, rd: ZERO_RD};

    ex_ctrl_t  dec_ctrl;
    ex_ctrl_t  ex_d,  ex_q;
    mem_ctrl_t mem_d, mem_q;
    wb_ctrl_t  wb_d,  wb_q;
    logic      legal;
    logic      uses_rn;
    logic      uses_rm;

    // NOTE: every always_comb output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        dec_ctrl = EX_BUBBLE;
        legal    = 1'b1;
        uses_rn  = 1'b1;
        uses_rm  = 1'b0;
        casez (id_opcode)
            11'b11111000010: begin
                dec_ctrl.alusrc   = 1'b1;
                dec_ctrl.memtoreg = 1'b1;
                dec_ctrl.regwrite = 1'b1;
                dec_ctrl.memread  = 1'b1;
            end
            11'b11111000000: begin
                dec_ctrl.alusrc   = 1'b1;
                dec_ctrl.memwrite = 1'b1;
                uses_rm           = 1'b1;
            end
            11'b10110100???: begin
                dec_ctrl.branch = 1'b1;
                dec_ctrl.aluop  = 2'b01;
                uses_rm         = 1'b1;
            end
            11'b000101?????: begin
                dec_ctrl.uncond = 1'b1;
                uses_rn         = 1'b0;
            end
            11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
                dec_ctrl.regwrite = 1'b1;
                dec_ctrl.aluop    = 2'b10;
                uses_rm           = 1'b1;
            end
            default: begin
                legal   = 1'b0;
                uses_rn = 1'b0;
            end
        endcase
        if (legal) dec_ctrl.rd = id_rd;
        // Invalid ID slots and illegal opcodes both travel as bubbles and read nothing.
        if (!id_valid) begin
            dec_ctrl = EX_BUBBLE;
            uses_rn  = 1'b0;
            uses_rm  = 1'b0;
        end
    end

    assign id_illegal = id_valid & ~legal;

    assign stall = id_valid & ex_q.memread & (ex_q.rd != ZERO_RD) &
                   ((uses_rn & (id_rn == ex_q.rd)) | (uses_rm & (id_rm == ex_q.rd)));

    always_comb begin
        ex_d  = dec_ctrl;
        mem_d = '{memread: ex_q.memread, memwrite: ex_q.memwrite, branch: ex_q.branch,
                  uncond: ex_q.uncond, regwrite: ex_q.regwrite, memtoreg: ex_q.memtoreg,
                  rd: ex_q.rd};
        wb_d  = '{regwrite: mem_q.regwrite, memtoreg: mem_q.memtoreg, rd: mem_q.rd};
        // Flush outranks stall: the branch in EX/MEM still retires into MEM/WB.
        if (flush) begin
            ex_d  = EX_BUBBLE;
            mem_d = MEM_BUBBLE;
        end else if (stall) begin
            ex_d = EX_BUBBLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all three stages sample the old values on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= EX_BUBBLE;
            mem_q <= MEM_BUBBLE;
            wb_q  <= WB_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_alusrc    = ex_q.alusrc;
    assign ex_aluop     = ex_q.aluop;
    assign ex_rd        = ex_q.rd;
    assign mem_memread  = mem_q.memread;
    assign mem_memwrite = mem_q.memwrite;
    assign mem_branch   = mem_q.branch;
    assign mem_uncond   = mem_q.uncond;
    assign mem_rd       = mem_q.rd;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_rd        = wb_q.rd;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: decode table, hand-written
// hazard/flush/reset sequences, then randomized traffic against a stage-slot model.
module tb_pipelined_control_unit;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_BAD  = 11'b11111111111;

    logic        clk, rst, id_valid, flush;
    logic [10:0] id_opcode;
    logic [4:0]  id_rn, id_rm, id_rd;
    logic        stall, id_illegal, ex_alusrc, mem_memread, mem_memwrite;
    logic        mem_branch, mem_uncond, wb_regwrite, wb_memtoreg;
    logic [1:0]  ex_aluop;
    logic [4:0]  ex_rd, mem_rd, wb_rd;

    pipelined_control_unit dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .flush(flush),
        .stall(stall), .id_illegal(id_illegal), .ex_alusrc(ex_alusrc),
        .ex_aluop(ex_aluop), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_branch(mem_branch), .mem_uncond(mem_uncond), .wb_regwrite(wb_regwrite),
        .wb_memtoreg(wb_memtoreg), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grouped per-stage views: {alusrc, aluop, rd}, {memread, memwrite, branch, uncond, rd}, {regwrite, memtoreg, rd}.
    logic [7:0] act_ex;
    logic [8:0] act_mem;
    logic [6:0] act_wb;
    assign act_ex  = {ex_alusrc, ex_aluop, ex_rd};
    assign act_mem = {mem_memread, mem_memwrite, mem_branch, mem_uncond, mem_rd};
    assign act_wb  = {wb_regwrite, wb_memtoreg, wb_rd};

    int n_checks = 0;
    int n_errors = 0;
    logic       log_en = 1'b0;
    logic [4:0] log_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (log_en && wb_regwrite) log_q.push_back(wb_rd);
    endtask

    task automatic drive(input logic v, input logic [10:0] op, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [4:0] rd);
        id_valid  = v;
        id_opcode = op;
        id_rn     = rn;
        id_rm     = rm;
        id_rd     = rd;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 11'd0, 5'd0, 5'd0, 5'd0);
        flush = 1'b0;
        repeat (n) tick();
    endtask

    task automatic check_bubbles(input string tag);
        check({tag, "_ex"},  act_ex,  32'h1F);
        check({tag, "_mem"}, act_mem, 32'h1F);
        check({tag, "_wb"},  act_wb,  32'h1F);
    endtask

    // ---------------- decode table ----------------
    typedef struct {
        logic [10:0] op;
        logic        ill;
        logic [2:0]  ex_c;   // alusrc, aluop
        logic [3:0]  mem_c;  // memread, memwrite, branch, uncond
        logic [1:0]  wb_c;   // regwrite, memtoreg
        logic        keep_rd;
    } dvec_t;

    dvec_t dv[12];

    // ---------------- behavioural model ----------------
    typedef enum logic [3:0] {K_NOP, K_LDUR, K_STUR, K_CBZ, K_B, K_ADD, K_SUB, K_AND,
                              K_ORR, K_ILL} kind_e;
    typedef struct packed {
        kind_e      k;
        logic [4:0] rd;
    } slot_t;

    function automatic slot_t bubble_slot();
        return '{k: K_NOP, rd: 5'd31};
    endfunction

    function automatic logic is_rtype(input kind_e k);
        return k inside {K_ADD, K_SUB, K_AND, K_ORR};
    endfunction

    function automatic logic [2:0] m_ex_bits(input kind_e k);
        if (k == K_LDUR || k == K_STUR) return 3'b100;
        if (k == K_CBZ)                 return 3'b001;
        if (is_rtype(k))                return 3'b010;
        return 3'b000;
    endfunction

    function automatic logic [3:0] m_mem_bits(input kind_e k);
        case (k)
            K_LDUR:  return 4'b1000;
            K_STUR:  return 4'b0100;
            K_CBZ:   return 4'b0010;
            K_B:     return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [1:0] m_wb_bits(input kind_e k);
        if (k == K_LDUR) return 2'b11;
        if (is_rtype(k)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic reads_rn(input kind_e k);
        return k inside {K_LDUR, K_STUR, K_CBZ, K_ADD, K_SUB, K_AND, K_ORR};
    endfunction

    function automatic logic reads_rm(input kind_e k);
        return k inside {K_STUR, K_CBZ, K_ADD, K_SUB, K_AND, K_ORR};
    endfunction

    function automatic logic [10:0] opcode_of(input kind_e k);
        logic [10:0] bad[4];
        bad[0] = OP_BAD;
        bad[1] = 11'b11111000001;
        bad[2] = 11'b10110101000;
        bad[3] = 11'b00010000000;
        case (k)
            K_LDUR:  return OP_LDUR;
            K_STUR:  return OP_STUR;
            K_CBZ:   return {8'b10110100, 3'($urandom)};
            K_B:     return {6'b000101, 5'($urandom)};
            K_ADD:   return OP_ADD;
            K_SUB:   return OP_SUB;
            K_AND:   return OP_AND;
            K_ORR:   return OP_ORR;
            default: return bad[$urandom_range(0, 3)];
        endcase
    endfunction

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 4) == 0) return 5'd31;
        return 5'($urandom_range(0, 3));
    endfunction

    slot_t       m_ex, m_mem, m_wb, n_ex;
    kind_e       cur_k;
    logic        cur_v, hold, exp_stall, exp_ill;
    logic [10:0] cur_op;
    logic [4:0]  cur_rn, cur_rm, cur_rd;

    initial begin
        dv[0]  = '{OP_LDUR,        1'b0, 3'b100, 4'b1000, 2'b11, 1'b1};
        dv[1]  = '{OP_STUR,        1'b0, 3'b100, 4'b0100, 2'b00, 1'b1};
        dv[2]  = '{11'b10110100101, 1'b0, 3'b001, 4'b0010, 2'b00, 1'b1};
        dv[3]  = '{11'b00010110110, 1'b0, 3'b000, 4'b0001, 2'b00, 1'b1};
        dv[4]  = '{OP_ADD,         1'b0, 3'b010, 4'b0000, 2'b10, 1'b1};
        dv[5]  = '{OP_SUB,         1'b0, 3'b010, 4'b0000, 2'b10, 1'b1};
        dv[6]  = '{OP_AND,         1'b0, 3'b010, 4'b0000, 2'b10, 1'b1};
        dv[7]  = '{OP_ORR,         1'b0, 3'b010, 4'b0000, 2'b10, 1'b1};
        dv[8]  = '{OP_BAD,         1'b1, 3'b000, 4'b0000, 2'b00, 1'b0};
        dv[9]  = '{11'b11111000001, 1'b1, 3'b000, 4'b0000, 2'b00, 1'b0};
        dv[10] = '{11'b10110101000, 1'b1, 3'b000, 4'b0000, 2'b00, 1'b0};
        dv[11] = '{11'b00010000000, 1'b1, 3'b000, 4'b0000, 2'b00, 1'b0};

        rst = 1'b1;
        idle(0);
        #1;
        check_bubbles("reset");
        check("reset_stall", stall, 0);
        repeat (2) tick();
        rst = 1'b0;
        idle(2);

        // Decode sweep: one instruction at a time, followed down the pipe.
        for (int i = 0; i < 12; i++) begin
            logic [4:0] erd;
            erd = dv[i].keep_rd ? 5'(i + 1) : 5'd31;
            drive(1'b1, dv[i].op, 5'd0, 5'd0, 5'(i + 1));
            #1;
            check($sformatf("dec%0d_illegal", i), id_illegal, dv[i].ill);
            check($sformatf("dec%0d_stall", i), stall, 0);
            tick();
            idle(0);
            check($sformatf("dec%0d_ex", i), act_ex, {dv[i].ex_c, erd});
            tick();
            check($sformatf("dec%0d_mem", i), act_mem, {dv[i].mem_c, erd});
            tick();
            check($sformatf("dec%0d_wb", i), act_wb, {dv[i].wb_c, erd});
        end
        idle(2);

        // Reset mid-stream while a load-use stall is active.
        drive(1'b1, OP_LDUR, 5'd0, 5'd0, 5'd2);
        tick();
        drive(1'b1, OP_ADD, 5'd2, 5'd4, 5'd3);
        #1;
        check("rst_pre_stall", stall, 1);
        rst = 1'b1;
        #1;
        check_bubbles("rst_mid");
        check("rst_mid_stall", stall, 0);
        idle(2);
        rst = 1'b0;
        drive(1'b1, OP_ADD, 5'd2, 5'd4, 5'd3);
        #1;
        check("rst_after_stall", stall, 0);
        tick();
        idle(3);

        // Load-use: LDUR X2 ; ADD X3, X2, X4.
        drive(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd2);
        tick();
        drive(1'b1, OP_ADD, 5'd2, 5'd4, 5'd3);
        #1;
        check("lu_stall", stall, 1);
        tick();
        check("lu_stall_once", stall, 0);
        check("lu_bubble_ex", act_ex, 32'h1F);
        check("lu_load_mem", act_mem, {4'b1000, 5'd2});
        tick();
        idle(0);
        check("lu_add_ex", act_ex, {3'b010, 5'd3});
        check("lu_bubble_mem", act_mem, 32'h1F);
        check("lu_load_wb", act_wb, {2'b11, 5'd2});
        idle(3);

        // No false hazards; then true hazards through rm.
        drive(1'b1, OP_LDUR, 5'd0, 5'd0, 5'd31);
        tick();
        drive(1'b1, OP_ADD, 5'd31, 5'd31, 5'd5);
        #1;
        check("nf_xzr", stall, 0);
        tick();
        idle(3);
        drive(1'b1, OP_LDUR, 5'd0, 5'd0, 5'd2);
        tick();
        drive(1'b1, OP_B, 5'd2, 5'd2, 5'd0);
        #1;
        check("nf_branch", stall, 0);
        tick();
        idle(3);
        drive(1'b1, OP_LDUR, 5'd0, 5'd0, 5'd2);
        tick();
        drive(1'b1, OP_ADD, 5'd7, 5'd8, 5'd5);
        #1;
        check("nf_indep", stall, 0);
        tick();
        drive(1'b1, OP_ADD, 5'd2, 5'd2, 5'd6);
        #1;
        check("nf_two_later", stall, 0);
        tick();
        idle(3);
        drive(1'b1, OP_LDUR, 5'd0, 5'd0, 5'd2);
        tick();
        drive(1'b1, OP_STUR, 5'd5, 5'd2, 5'd0);
        #1;
        check("hz_stur_rm", stall, 1);
        idle(3);
        drive(1'b1, OP_LDUR, 5'd0, 5'd0, 5'd2);
        tick();
        drive(1'b1, OP_CBZ, 5'd6, 5'd2, 5'd0);
        #1;
        check("hz_cbz_rm", stall, 1);
        idle(3);

        // Flush while CBZ is in MEM and a load-use stall is pending.
        drive(1'b1, OP_CBZ, 5'd0, 5'd1, 5'd9);
        tick();
        drive(1'b1, OP_LDUR, 5'd0, 5'd0, 5'd2);
        tick();
        drive(1'b1, OP_ADD, 5'd2, 5'd2, 5'd3);
        flush = 1'b1;
        #1;
        check("fl_stall_active", stall, 1);
        check("fl_cbz_mem", act_mem, {4'b0010, 5'd9});
        tick();
        idle(0);
        check("fl_ex", act_ex, 32'h1F);
        check("fl_mem", act_mem, 32'h1F);
        check("fl_wb", act_wb, {2'b00, 5'd9});
        check("fl_stall_after", stall, 0);
        idle(4);

        // Back-to-back loads: LDUR X1 ; LDUR X2,[X1] ; ADD X3,X2,X2.
        log_q.delete();
        log_en = 1'b1;
        drive(1'b1, OP_LDUR, 5'd0, 5'd0, 5'd1);
        tick();
        drive(1'b1, OP_LDUR, 5'd1, 5'd0, 5'd2);
        #1;
        check("b2b_stall1", stall, 1);
        tick();
        check("b2b_stall1_once", stall, 0);
        tick();
        drive(1'b1, OP_ADD, 5'd2, 5'd2, 5'd3);
        #1;
        check("b2b_stall2", stall, 1);
        tick();
        check("b2b_stall2_once", stall, 0);
        tick();
        idle(6);
        log_en = 1'b0;
        check("b2b_retired", log_q.size(), 3);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b_wb_rd%0d", i), (i < log_q.size()) ? log_q[i] : 5'd0, i + 1);

        // Randomized traffic against the slot model.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        m_ex  = bubble_slot();
        m_mem = bubble_slot();
        m_wb  = bubble_slot();
        hold  = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (!hold) begin
                cur_v  = ($urandom_range(0, 7) != 0);
                cur_k  = kind_e'($urandom_range(1, 9));
                cur_op = opcode_of(cur_k);
                cur_rn = pick_reg();
                cur_rm = pick_reg();
                cur_rd = pick_reg();
            end
            drive(cur_v, cur_op, cur_rn, cur_rm, cur_rd);
            flush = ($urandom_range(0, 15) == 0);
            #1;
            exp_stall = cur_v && m_ex.k == K_LDUR && m_ex.rd != 5'd31 &&
                        ((reads_rn(cur_k) && cur_rn == m_ex.rd) ||
                         (reads_rm(cur_k) && cur_rm == m_ex.rd));
            exp_ill = cur_v && cur_k == K_ILL;
            check("rnd_stall", stall, exp_stall);
            check("rnd_illegal", id_illegal, exp_ill);
            check("rnd_ex", act_ex, {m_ex_bits(m_ex.k), m_ex.rd});
            check("rnd_mem", act_mem, {m_mem_bits(m_mem.k), m_mem.rd});
            check("rnd_wb", act_wb, {m_wb_bits(m_wb.k), m_wb.rd});
            if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                #1;
                check_bubbles("rnd_rst");
                check("rnd_rst_stall", stall, 0);
                tick();
                rst   = 1'b0;
                m_ex  = bubble_slot();
                m_mem = bubble_slot();
                m_wb  = bubble_slot();
                hold  = 1'b0;
                continue;
            end
            if (flush || exp_stall || !cur_v || cur_k == K_ILL) n_ex = bubble_slot();
            else n_ex = '{k: cur_k, rd: cur_rd};
            tick();
            m_wb  = m_mem;
            m_mem = flush ? bubble_slot() : m_ex;
            m_ex  = n_ex;
            hold  = exp_stall && !flush;
        end
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Decodes the LEGv8 opcode of the instruction in ID and carries its control word through ID/EX, EX/MEM and MEM/WB pipeline registers. Each stage's control outputs are timed to its datapath stage. Includes load-use hazard detection with bubble insertion, and a branch flush.

Parameters:
OPCODE_W, 11, opcode field width (instr[31:21])
REG_W, 5, register address width
ZERO_REG, 31, XZR index; never creates a hazard

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
id_valid  input  1  ID holds a real instruction
id_opcode  input  OPCODE_W  opcode of ID instruction
id_rn  input  REG_W  first source register
id_rm  input  REG_W  second source (datapath supplies Rt here for STUR/CBZ)
id_rd  input  REG_W  destination register
flush  input  1  taken branch resolved in MEM
stall  output  1  hold PC and IF/ID (combinational)
id_illegal  output  1  valid ID opcode not in decode table (combinational)
ex_alusrc  output  1  ALU B = immediate
ex_aluop  output  2  ALU control class
mem_memread  output  1  data-memory read
mem_memwrite  output  1  data-memory write
mem_branch  output  1  conditional branch (CBZ)
mem_uncond  output  1  unconditional branch (B)
wb_regwrite  output  1  register-file write
wb_memtoreg  output  1  writeback from memory
ex_rd, mem_rd, wb_rd  output  REG_W each  destination per stage, for forwarding

Behaviour:
- Decode (combinational, ID). Fields: alusrc, memtoreg, regwrite, memread, memwrite, branch, uncond, aluop.
  - LDUR 11111000010: 1 1 1 1 0 0 0 00
  - STUR 11111000000: 1 0 0 0 1 0 0 00
  - CBZ 10110100xxx: 0 0 0 0 0 1 0 01
  - B 000101xxxxx: 0 0 0 0 0 0 1 00
  - R-type ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: 0 0 1 0 0 0 0 10
- Don't-cares are resolved to 0; no X ever leaves the block.
- Any other opcode with id_valid=1: id_illegal=1, decodes as all-zero bubble.
- Source use:
  - rn is read by all opcodes except B.
  - rm is read by R-type, STUR and CBZ.
- Hazard (combinational): stall=1 when all of the following hold:
  - id_valid;
  - the EX stage holds a valid load (memread=1 in ID/EX);
  - ex_rd != ZERO_REG;
  - ex_rd equals a source register read by the ID opcode.
- Register update on each clk edge, in priority order:
  - flush=1: ID/EX and EX/MEM load bubbles. MEM/WB loads the EX/MEM content normally, so the branch retires. stall is ignored.
  - stall=1: ID/EX loads a bubble. EX/MEM and MEM/WB advance.
  - Otherwise: all three registers advance; ID/EX loads the decode word (bubble if !id_valid).
- A bubble is all control bits 0 and rd=ZERO_REG.
- Latency:
  - ex_* outputs reflect an ID instruction 1 cycle after it is accepted.
  - mem_* outputs: 2 cycles.
  - wb_* outputs: 3 cycles.
- Outputs are driven straight from the stage registers, with no combinational path from inputs except stall and id_illegal.
- Reset (async, any time, including mid-hazard): all stage control bits 0 and ex_rd/mem_rd/wb_rd = ZERO_REG. stall therefore reads 0 during and immediately after reset. Pipeline refills from the first id_valid after rst deasserts.
- Consecutive loads: a load stalled behind a load proceeds after one bubble. A second dependent instruction then stalls again as required.

Test Plan:
- Reset mid-stream: issue LDUR, assert rst before it reaches WB -> all outputs 0, *_rd=31 immediately. Next cycle after deassert, stall=0.
- Decode sweep, one opcode per cycle with no dependences:
  - LDUR -> ex_alusrc=1, ex_aluop=00; mem_memread=1; wb_regwrite=1, wb_memtoreg=1 at cycles +1/+2/+3.
  - STUR -> mem_memwrite=1, wb_regwrite=0.
  - CBZ -> ex_aluop=01, mem_branch=1.
  - B -> mem_uncond=1.
  - SUB -> ex_aluop=10, wb_regwrite=1.
  - Opcode 11111111111 -> id_illegal=1 and a bubble propagates.
- Load-use: LDUR X2 then ADD X3,X2,X4:
  - stall=1 for exactly one cycle.
  - ex_* all 0 in the following cycle.
  - ADD reaches EX one cycle later with ex_rd=3.
- No false hazard, each case stall=0:
  - LDUR XZR followed by ADD reading X31.
  - LDUR X2 followed by B.
  - LDUR X2 followed by ADDs reading X2 two cycles later.
- Flush priority: CBZ in MEM, assert flush while a load-use stall is active -> next cycle:
  - ex_* and mem_* bubbles (all 0).
  - wb_rd reflects CBZ with wb_regwrite=0.
  - stall has no effect.
- Back-to-back loads: LDUR X1, LDUR X2,[X1], ADD X3,X2,X2 -> two separate single-cycle stalls. All three instructions retire in order with wb_rd = 1, 2, 3.
